// File: rtl/dsram_responder.sv
// dsram_responder: word-organised, byte-write-enabled data SRAM with a fixed read
// latency, out-of-range flagging and saturating read/write access counters.
module dsram_responder #(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        rdata_valid,
    output logic        addr_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);
    localparam int          DEPTH   = 1 << ADDR_W;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
            $error("dsram_responder: RD_LAT must lie in 1..4");
        end
    endgenerate

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  lane_en
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [ADDR_W-1:0] word_idx_s;
    logic              out_of_range_s;
    logic              is_rd_s;
    logic              is_wr_s;
    logic [31:0]       iss_data_s;
    logic              unused_s;

    logic [31:0]       mem_r [DEPTH];

    logic [RD_LAT-1:0] vld_r;
    logic [RD_LAT-1:0] err_r;
    logic [31:0]       data_r    [RD_LAT];
    logic [RD_LAT-1:0] vld_in_s;
    logic [RD_LAT-1:0] err_in_s;
    logic [31:0]       data_in_s [RD_LAT];

    // Gating every class with en keeps unknown wen/addr on idle cycles harmless.
    assign word_idx_s     = data_sram_addr[ADDR_W+1:2];
    assign out_of_range_s = |data_sram_addr[31:ADDR_W+2];
    assign is_rd_s        = data_sram_en & (data_sram_wen == 4'h0);
    assign is_wr_s        = data_sram_en & (data_sram_wen != 4'h0);
    assign unused_s       = &{1'b0, data_sram_addr[1:0]};

    // Word captured at the issuing edge; out-of-range reads return zero.
    always_comb begin
        iss_data_s = 32'h0;
        if (is_rd_s && !out_of_range_s) begin
            iss_data_s = mem_r[word_idx_s];
        end else begin
            iss_data_s = 32'h0;
        end
    end

    // Stage inputs: stage 0 takes the new access, later stages shift from their predecessor.
    always_comb begin
        vld_in_s     = '0;
        err_in_s     = '0;
        vld_in_s[0]  = is_rd_s;
        err_in_s[0]  = data_sram_en & out_of_range_s;
        data_in_s[0] = iss_data_s;
        for (int k = 1; k < RD_LAT; k++) begin
            vld_in_s[k]  = vld_r[k-1];
            err_in_s[k]  = err_r[k-1];
            data_in_s[k] = data_r[k-1];
        end
    end

    // Latency pipeline; data only moves with a valid read so the last stage holds between completions.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_r <= '0;
            err_r <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                data_r[k] <= 32'h0;
            end
        end else begin
            vld_r <= vld_in_s;
            err_r <= err_in_s;
            for (int k = 0; k < RD_LAT; k++) begin
                if (vld_in_s[k]) begin
                    data_r[k] <= data_in_s[k];
                end else begin
                    data_r[k] <= data_r[k];
                end
            end
        end
    end

    // Byte-lane write into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && is_wr_s && !out_of_range_s) begin
            mem_r[word_idx_s] <= merge_lanes(mem_r[word_idx_s], data_sram_wdata, data_sram_wen);
        end
    end

    // Saturating access counters, counting out-of-range accesses too.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt <= 32'h0;
            wr_cnt <= 32'h0;
        end else begin
            if (is_rd_s && rd_cnt != CNT_MAX) begin
                rd_cnt <= rd_cnt + 32'h1;
            end else begin
                rd_cnt <= rd_cnt;
            end
            if (is_wr_s && wr_cnt != CNT_MAX) begin
                wr_cnt <= wr_cnt + 32'h1;
            end else begin
                wr_cnt <= wr_cnt;
            end
        end
    end

    assign data_sram_rdata = data_r[RD_LAT-1];
    assign rdata_valid     = vld_r[RD_LAT-1];
    assign addr_err        = err_r[RD_LAT-1];

endmodule

// File: tb/tb_dsram_responder.sv
// Scoreboard bench for dsram_responder: two instances (RD_LAT 1 and 3) share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_dsram_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  wen = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    logic [31:0] r1_rdata, r1_rd_cnt, r1_wr_cnt;
    logic        r1_valid, r1_err;
    logic [31:0] r3_rdata, r3_rd_cnt, r3_wr_cnt;
    logic        r3_valid, r3_err;

    always #5 clk = ~clk;

    dsram_responder #(.ADDR_W(14), .RD_LAT(1)) u_dut_lat1 (
        .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(r1_rdata),
        .rdata_valid(r1_valid), .addr_err(r1_err), .rd_cnt(r1_rd_cnt), .wr_cnt(r1_wr_cnt)
    );

    dsram_responder #(.ADDR_W(14), .RD_LAT(3)) u_dut_lat3 (
        .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(r3_rdata),
        .rdata_valid(r3_valid), .addr_err(r3_err), .rd_cnt(r3_rd_cnt), .wr_cnt(r3_wr_cnt)
    );

    typedef struct {
        logic [31:0] data;
        logic        vld;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q1[$];
    exp_t        q3[$];
    logic [31:0] model_mem [int];
    logic [31:0] hold1 = 32'h0;
    logic [31:0] hold3 = 32'h0;
    logic [31:0] mdl_rd_cnt = 32'h0;
    logic [31:0] mdl_wr_cnt = 32'h0;
    int          cyc = 0;
    int          checks_total = 0;
    int          checks_passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic monitor(input int lat, input logic v, input logic e, input logic [31:0] rd,
                           input logic [31:0] rc, input logic [31:0] wc);
        exp_t  f;
        string p;
        f = '{32'h0, 1'b0, 1'b0, cyc};
        if (lat == 1) begin
            p = "lat1";
            if (q1.size() > 0 && q1[0].due == cyc) f = q1.pop_front();
            if (f.vld) hold1 = f.data;
            f.data = hold1;
        end else begin
            p = "lat3";
            if (q3.size() > 0 && q3[0].due == cyc) f = q3.pop_front();
            if (f.vld) hold3 = f.data;
            f.data = hold3;
        end
        check({p, "_valid"}, {31'h0, v}, {31'h0, f.vld});
        check({p, "_addr_err"}, {31'h0, e}, {31'h0, f.err});
        check({p, "_rdata"}, rd, f.data);
        check({p, "_rd_cnt"}, rc, mdl_rd_cnt);
        check({p, "_wr_cnt"}, wc, mdl_wr_cnt);
    endtask

    task automatic access(input logic e, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d, input logic rst);
        exp_t x;
        int   idx;
        logic oor;
        reset = rst;
        en    = e;
        wen   = w;
        addr  = a;
        wdata = d;
        oor   = (a[31:16] != 16'h0);
        idx   = int'(a[15:2]);
        if (!rst && e === 1'b1) begin
            if (w == 4'h0) begin
                x.vld  = 1'b1;
                x.err  = oor;
                x.data = oor ? 32'h0 : model_mem[idx];
                x.due  = cyc + 1;
                q1.push_back(x);
                x.due  = cyc + 3;
                q3.push_back(x);
                if (mdl_rd_cnt != 32'hFFFF_FFFF) mdl_rd_cnt = mdl_rd_cnt + 32'h1;
            end else begin
                if (mdl_wr_cnt != 32'hFFFF_FFFF) mdl_wr_cnt = mdl_wr_cnt + 32'h1;
                if (oor) begin
                    x = '{32'h0, 1'b0, 1'b1, cyc + 1};
                    q1.push_back(x);
                    x.due = cyc + 3;
                    q3.push_back(x);
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (w[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
                    end
                end
            end
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            q1.delete();
            q3.delete();
            hold1      = 32'h0;
            hold3      = 32'h0;
            mdl_rd_cnt = 32'h0;
            mdl_wr_cnt = 32'h0;
        end
        #1;
        monitor(1, r1_valid, r1_err, r1_rdata, r1_rd_cnt, r1_wr_cnt);
        monitor(3, r3_valid, r3_err, r3_rdata, r3_rd_cnt, r3_wr_cnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) access(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        access(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        access(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        idle(1);

        // Full-word store then load
        access(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        access(1'b1, 4'h0, 32'h0000_0010, 32'h0, 1'b0);
        idle(3);

        // Partial lanes, unaligned address
        access(1'b1, 4'h4, 32'h0000_0010, 32'h00AA_0000, 1'b0);
        access(1'b1, 4'h3, 32'h0000_0010, 32'h0000_1234, 1'b0);
        access(1'b1, 4'h0, 32'h0000_0013, 32'h0, 1'b0);
        idle(3);

        // Back-to-back reads complete in order
        access(1'b1, 4'hF, 32'h0000_0100, 32'h1, 1'b0);
        access(1'b1, 4'hF, 32'h0000_0104, 32'h2, 1'b0);
        access(1'b1, 4'hF, 32'h0000_0108, 32'h3, 1'b0);
        access(1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b0);
        access(1'b1, 4'h0, 32'h0000_0104, 32'h0, 1'b0);
        access(1'b1, 4'h0, 32'h0000_0108, 32'h0, 1'b0);
        idle(5);

        // Out-of-range write and read
        access(1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 1'b0);
        access(1'b1, 4'hF, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0);
        access(1'b1, 4'h0, 32'h0001_0000, 32'h0, 1'b0);
        access(1'b1, 4'h0, 32'h0000_0000, 32'h0, 1'b0);
        idle(4);

        // Reset while a read is in flight
        access(1'b1, 4'h0, 32'h0000_0010, 32'h0, 1'b0);
        access(1'b1, 4'hF, 32'h0000_0010, 32'h0, 1'b1);
        idle(5);
        access(1'b1, 4'h0, 32'h0000_0010, 32'h0, 1'b0);
        idle(4);

        // Disabled accesses, including unknown wen/addr
        for (int i = 0; i < 5; i++) access(1'b0, 4'hF, 32'h0000_0010, 32'h0, 1'b0);
        access(1'b0, 4'bxxxx, 32'hxxxx_xxxx, 32'h0, 1'b0);
        access(1'b0, 4'bxxxx, 32'hxxxx_xxxx, 32'h0, 1'b0);
        access(1'b1, 4'h0, 32'h0000_0010, 32'h0, 1'b0);
        idle(4);

        // Random mix over a small pre-initialised window
        for (int i = 0; i < 8; i++) access(1'b1, 4'hF, 32'h200 + 32'(i * 4), $urandom, 1'b0);
        for (int i = 0; i < 300; i++) begin
            int          r;
            logic [31:0] a;
            r = int'($urandom_range(0, 9));
            a = 32'h200 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            if (r < 4) access(1'b1, 4'h0, a, 32'h0, 1'b0);
            else if (r < 8) access(1'b1, 4'($urandom_range(1, 15)), a, $urandom, 1'b0);
            else if (r == 8) access(1'b1, 4'($urandom_range(0, 15)), 32'h0001_0000 | $urandom, $urandom, 1'b0);
            else access(1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom, 1'b0);
        end
        idle(5);
        check("lat1_drained", 32'(q1.size()), 32'h0);
        check("lat3_drained", 32'(q3.size()), 32'h0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
